studio2_keypad: RTL and testbench
=================================

STUDIO2_KEYPAD -- requirements
Module: studio2_keypad

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16'd50000, the minimum clk cycles a keypress is reported after its make event.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ps2_key  input  11  PS/2 event: [10] toggles per event, [9] pressed, [8] extended, [7:0] scan code.
REQ-005 SHALL have port io_out  input  1  CPU OUT-cycle strobe, one clk wide.
REQ-006 SHALL have port io_n  input  3  CPU N lines (I/O port number).
REQ-007 SHALL have port io_dout  input  8  CPU OUT data byte.
REQ-008 SHALL have port ef  output  4  external flags to CPU: [2] keypad 1 hit, [3] keypad 2 hit, [1:0] tied 0.
REQ-009 SHALL have port key_sel  output  4  currently latched key-select nibble.

Function
REQ-010 SHALL detect a PS/2 event when ps2_key[10] differs from its value registered on the previous clk; one event per change.
REQ-011 SHALL ignore events with ps2_key[8]=1 and events whose code is not mapped.
REQ-012 SHALL map keypad 1 keys 0-9 to codes 45,16,1E,26,25,2E,36,3D,3E,46 (hex).
REQ-013 SHALL map keypad 2 keys 0-9 to codes 70,69,72,7A,6B,73,74,6C,75,7D (hex, numeric pad).
REQ-014 SHALL keep a 10-bit held vector per keypad; a mapped event writes ps2_key[9] into the bit for that key, one cycle after the event.
REQ-015 SHALL keep per keypad a stretch register: hold_key (4 bits) and hold_cnt (16 bits); a mapped make event loads hold_key=key and hold_cnt=HOLD_CYCLES.
REQ-016 SHALL decrement hold_cnt by 1 each cycle when nonzero and saturate at 0; a new make event on the same keypad reloads it, even mid-count.
REQ-017 SHALL form effective vector = held OR (hold_cnt!=0 ? onehot(hold_key) : 0) per keypad.
REQ-018 SHALL latch key_sel <= io_dout[3:0] on any cycle with io_out=1 and io_n=3'd2; otherwise hold.
REQ-019 SHALL register ef[2] = keypad 1 effective[key_sel] and ef[3] = keypad 2 effective[key_sel], or 0 when key_sel>9; one-cycle latency from key_sel/effective change.
REQ-020 SHALL, when a PS/2 event and a select OUT occur in the same cycle, apply both; ef then reflects both on the cycle after next.
REQ-021 SHALL treat break events for a key not held as no-op; breaks never clear an active stretch.

Reset
REQ-022 SHALL on reset clear held vectors, hold_key, hold_cnt, key_sel, ef to 0, and load the event-detect register with the current ps2_key[10] so no event fires on reset release.
REQ-023 SHALL, when reset asserts mid-stretch or with keys held, drop ef to 0 immediately and report no keys afterwards until new make events.

Structure
REQ-024 SHALL place the two scan-code tables, the keypad I/O port number (2) and the EF bit indices in shared package studio2_pkg.
REQ-025 SHALL instantiate one sub-module studio2_key_stretch twice (one per keypad), holding hold_key/hold_cnt and producing the effective vector.
REQ-026 SHALL connect ef directly to the CPU EF input and io_n/io_out/io_dout to the CPU I/O outputs.

Verification
REQ-027 SHALL verify: OUT port 2 data 05, make 2E, wait 3 cycles -> ef=4'b0100; break 2E after HOLD_CYCLES -> ef=0 two cycles later.
REQ-028 SHALL verify: HOLD_CYCLES=20, make+break 16 within 2 cycles, key_sel=1 -> ef[2]=1 for ~20 cycles, then 0.
REQ-029 SHALL verify: make 7D held, key_sel=9 -> ef=4'b1000; key_sel=A -> ef=0 next cycle.
REQ-030 SHALL verify: extended event E0 70 and unmapped code 1C -> ef unchanged, held vectors unchanged.
REQ-031 SHALL verify: make 45 and key_sel=0 both held, assert reset mid-stretch -> ef=0 asynchronously; after release no event fires and ef stays 0.
REQ-032 SHALL verify: OUT on io_n=3 with data 04 -> key_sel unchanged.

Source files
------------

// File: rtl/studio2_pkg.sv
// Shared constants and helpers for the Studio II keypad block: scan-code
// tables for both keypads, the keypad select I/O port and EF bit positions.
package studio2_pkg;

    // CPU I/O port number that latches the key-select nibble.
    localparam logic [2:0] KEYPAD_PORT = 3'd2;

    // Bit positions inside the 4-bit EF bus.
    localparam int EF_KP1 = 2;
    localparam int EF_KP2 = 3;

    // Scan codes, key 0 in the least significant byte.
    localparam logic [79:0] KP1_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                         8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
    localparam logic [79:0] KP2_CODES = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                         8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

    typedef struct packed {
        logic       hit;
        logic [3:0] key;
    } key_hit_t;

    // Search one keypad table for a scan code.
    function automatic key_hit_t lookup(input logic [79:0] codes, input logic [7:0] code);
        key_hit_t res;
        res.hit = 1'b0;
        res.key = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (codes[i*8 +: 8] == code) begin
                res.hit = 1'b1;
                res.key = 4'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Select one key of a 10-key vector; selects above 9 read as not pressed.
    function automatic logic pick(input logic [9:0] vec, input logic [3:0] sel);
        logic [15:0] ext;
        ext = {6'd0, vec};
        return ext[sel];
    endfunction

endpackage

// File: rtl/studio2_keypad_if.sv
// CPU OUT-cycle bus as seen by the keypad block.
interface studio2_keypad_if;
    logic       io_out;
    logic [2:0] io_n;
    logic [7:0] io_dout;

    modport master (output io_out, output io_n, output io_dout);
    modport slave  (input  io_out, input  io_n, input  io_dout);
endinterface

// File: rtl/studio2_key_stretch.sv
// Per-keypad pulse stretcher: keeps the most recent make event visible for
// at least HOLD_CYCLES clocks even if the key was released sooner.
module studio2_key_stretch
    import studio2_pkg::*;
#(
    parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_key,
    input  logic [9:0] held,
    output logic [9:0] effective
);

    logic [3:0]  hold_key_r;
    logic [15:0] hold_cnt_r;

    // Reload on every make event, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_key_r <= 4'd0;
            hold_cnt_r <= 16'd0;
        end else if (load) begin
            hold_key_r <= load_key;
            hold_cnt_r <= HOLD_CYCLES;
        end else if (hold_cnt_r != 16'd0) begin
            hold_cnt_r <= hold_cnt_r - 16'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Merge the live key state with the stretched key.
    always_comb begin
        effective = held;
        if (hold_cnt_r != 16'd0) begin
            effective = held | (10'd1 << hold_key_r);
        end else begin
            effective = held;
        end
    end

endmodule

// File: rtl/studio2_keypad.sv
// Studio II keypad emulation: turns PS/2 key events into two 10-key pads
// and reports the key chosen by the CPU-written select nibble on EF2/EF3.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       ps2_key,
    studio2_keypad_if.slave   io,
    output logic [3:0]        ef,
    output logic [3:0]        key_sel
);

    logic       tog_r;
    logic [9:0] held1_r;
    logic [9:0] held2_r;
    logic [9:0] eff1_s;
    logic [9:0] eff2_s;
    logic       accept_s;
    logic       load1_s;
    logic       load2_s;
    logic [3:0] ef_s;
    key_hit_t   hit1_s;
    key_hit_t   hit2_s;
    logic       unused_s;

    // Only the low nibble of the OUT data carries the key select.
    assign unused_s = ^io.io_dout[7:4];

    // Event detect and scan-code decode; extended codes are discarded.
    always_comb begin
        accept_s = (ps2_key[10] ^ tog_r) & ~ps2_key[8];
        hit1_s   = lookup(KP1_CODES, ps2_key[7:0]);
        hit2_s   = lookup(KP2_CODES, ps2_key[7:0]);
        load1_s  = accept_s & hit1_s.hit & ps2_key[9];
        load2_s  = accept_s & hit2_s.hit & ps2_key[9];
    end

    // Track the toggle bit; reset samples it so release raises no event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_r <= ps2_key[10];
        end else begin
            tog_r <= ps2_key[10];
        end
    end

    // Live pressed/released state of every mapped key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held1_r <= 10'd0;
            held2_r <= 10'd0;
        end else begin
            if (accept_s && hit1_s.hit) begin
                held1_r[hit1_s.key] <= ps2_key[9];
            end else begin
                held1_r <= held1_r;
            end
            if (accept_s && hit2_s.hit) begin
                held2_r[hit2_s.key] <= ps2_key[9];
            end else begin
                held2_r <= held2_r;
            end
        end
    end

    studio2_key_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch_kp1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1_s),
        .load_key  (hit1_s.key),
        .held      (held1_r),
        .effective (eff1_s)
    );

    studio2_key_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch_kp2 (
        .clk       (clk),
        .reset     (reset),
        .load      (load2_s),
        .load_key  (hit2_s.key),
        .held      (held2_r),
        .effective (eff2_s)
    );

    // Latch the key-select nibble written by the CPU to the keypad port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sel <= 4'd0;
        end else if (io.io_out && (io.io_n == KEYPAD_PORT)) begin
            key_sel <= io.io_dout[3:0];
        end else begin
            key_sel <= key_sel;
        end
    end

    // Flag value for the currently selected key on each pad.
    always_comb begin
        ef_s         = 4'd0;
        ef_s[EF_KP1] = pick(eff1_s, key_sel);
        ef_s[EF_KP2] = pick(eff2_s, key_sel);
    end

    // Registered EF outputs to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ef <= 4'd0;
        end else begin
            ef <= ef_s;
        end
    end

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad with a cycle-level reference model.
module tb_studio2_keypad;

    localparam int HOLD = 20;

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    logic [3:0]  ef;
    logic [3:0]  key_sel;
    logic        chk_en;
    int          total;
    int          bad;

    studio2_keypad_if bus ();

    studio2_keypad #(.HOLD_CYCLES(16'd20)) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_key (ps2_key),
        .io      (bus),
        .ef      (ef),
        .key_sel (key_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         m_held [2][10];
    bit         m_have [2];
    int         m_last_key [2];
    int         m_last_edge [2];
    int         edge_n;
    logic [3:0] m_sel;
    logic [3:0] m_ef;
    logic       m_tog;

    function automatic int kp1_key(input logic [7:0] c);
        case (c)
            8'h45: return 0;  8'h16: return 1;  8'h1E: return 2;  8'h26: return 3;
            8'h25: return 4;  8'h2E: return 5;  8'h36: return 6;  8'h3D: return 7;
            8'h3E: return 8;  8'h46: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic int kp2_key(input logic [7:0] c);
        case (c)
            8'h70: return 0;  8'h69: return 1;  8'h72: return 2;  8'h7A: return 3;
            8'h6B: return 4;  8'h73: return 5;  8'h74: return 6;  8'h6C: return 7;
            8'h75: return 8;  8'h7D: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic int code_key(input int pad, input logic [7:0] c);
        return (pad == 0) ? kp1_key(c) : kp2_key(c);
    endfunction

    // Key k of pad p is reported if held, or if it was the last make and
    // fewer than HOLD edges have passed since that make.
    function automatic bit eff_bit(input int p, input int k);
        return m_held[p][k] ||
               (m_have[p] && (m_last_key[p] == k) && ((edge_n - m_last_edge[p]) < HOLD));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_have[p] <= 1'b0;
                for (int k = 0; k < 10; k++) m_held[p][k] <= 1'b0;
            end
            m_tog  <= ps2_key[10];
            m_sel  <= 4'd0;
            m_ef   <= 4'd0;
            edge_n <= 0;
        end else begin
            edge_n <= edge_n + 1;
            m_ef <= {((m_sel < 4'd10) && eff_bit(1, int'(m_sel))),
                     ((m_sel < 4'd10) && eff_bit(0, int'(m_sel))), 2'b00};
            m_tog <= ps2_key[10];
            if (bus.io_out && bus.io_n == 3'd2) m_sel <= bus.io_dout[3:0];
            if ((ps2_key[10] != m_tog) && !ps2_key[8]) begin
                for (int p = 0; p < 2; p++) begin
                    if (code_key(p, ps2_key[7:0]) >= 0) begin
                        m_held[p][code_key(p, ps2_key[7:0])] <= ps2_key[9];
                        if (ps2_key[9]) begin
                            m_have[p]      <= 1'b1;
                            m_last_key[p]  <= code_key(p, ps2_key[7:0]);
                            m_last_edge[p] <= edge_n + 1;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (ef !== m_ef) begin
                bad++;
                $display("FAIL ef_model: got %b want %b at %0t", ef, m_ef, $time);
            end
            total++;
            if (key_sel !== m_sel) begin
                bad++;
                $display("FAIL key_sel_model: got %h want %h at %0t", key_sel, m_sel, $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic ext, input logic pressed, input logic [7:0] code);
        @(negedge clk);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic out(input logic [2:0] n, input logic [7:0] d);
        @(negedge clk);
        bus.io_out  = 1'b1;
        bus.io_n    = n;
        bus.io_dout = d;
        @(negedge clk);
        bus.io_out  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hits;
        total = 0;
        bad = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        ps2_key = 11'd0;
        bus.io_out = 1'b0;
        bus.io_n = 3'd0;
        bus.io_dout = 8'd0;
        wait_cyc(3);
        chk_en = 1'b1;
        check("reset_ef", 16'(ef), 16'h0);
        check("reset_key_sel", 16'(key_sel), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(2);
        check("idle_ef", 16'(ef), 16'h0);

        // Select key 5, press 2E (keypad 1 key 5).
        out(3'd2, 8'h05);
        send(1'b0, 1'b1, 8'h2E);
        wait_cyc(3);
        check("make_2e", 16'(ef), 16'h4);
        wait_cyc(HOLD + 5);
        check("held_after_stretch", 16'(ef), 16'h4);
        send(1'b0, 1'b0, 8'h2E);
        wait_cyc(1);
        check("break_2e_lat1", 16'(ef), 16'h4);
        wait_cyc(1);
        check("break_2e_lat2", 16'(ef), 16'h0);

        // Short tap of key 1 is stretched to HOLD cycles.
        out(3'd2, 8'h01);
        send(1'b0, 1'b1, 8'h16);
        send(1'b0, 1'b0, 8'h16);
        hits = 0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            @(negedge clk);
            if (ef[2]) hits++;
        end
        check("stretch_len", 16'(hits), 16'(HOLD));

        // Event and select OUT in the same cycle.
        @(negedge clk);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h3D};
        bus.io_out = 1'b1;
        bus.io_n = 3'd2;
        bus.io_dout = 8'h07;
        @(negedge clk);
        bus.io_out = 1'b0;
        check("same_cycle_lat1", 16'(ef), 16'h0);
        @(negedge clk);
        check("same_cycle_lat2", 16'(ef), 16'h4);

        // Keypad 2 key 9 held, then select out of range.
        send(1'b0, 1'b1, 8'h7D);
        out(3'd2, 8'h09);
        wait_cyc(2);
        check("kp2_key9", 16'(ef), 16'h8);
        out(3'd2, 8'h0A);
        check("sel_a_key_sel", 16'(key_sel), 16'hA);
        wait_cyc(1);
        check("sel_a_ef", 16'(ef), 16'h0);

        // Extended and unmapped events are ignored.
        out(3'd2, 8'h09);
        wait_cyc(2);
        send(1'b1, 1'b1, 8'h70);
        send(1'b0, 1'b1, 8'h1C);
        send(1'b1, 1'b0, 8'h7D);
        wait_cyc(3);
        check("ignored_ef_sel9", 16'(ef), 16'h8);
        out(3'd2, 8'h00);
        wait_cyc(2);
        check("ignored_ef_sel0", 16'(ef), 16'h0);

        // OUT to another port leaves key_sel alone.
        out(3'd3, 8'h04);
        wait_cyc(1);
        check("other_port", 16'(key_sel), 16'h0);

        // Reset in the middle of a stretch with a key held.
        send(1'b0, 1'b1, 8'h45);
        wait_cyc(2);
        check("pre_reset_ef", 16'(ef), 16'h4);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_ef", 16'(ef), 16'h0);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
        wait_cyc(3);
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ef != 4'd0) hits++;
        end
        check("post_reset_quiet", 16'(hits), 16'h0);
        out(3'd2, 8'h01);
        wait_cyc(2);
        check("post_reset_key1", 16'(ef), 16'h0);
        out(3'd2, 8'h09);
        wait_cyc(2);
        check("post_reset_key9", 16'(ef), 16'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
